// File: rtl/spi_flash_responder.sv
// SPI-flash slave (mode 0) oversampled in the sys_clk domain.
// Serves READ (0x03), READ ID (0x9F) and READ STATUS (0x05) from an external byte memory.
module spi_flash_responder #(
    parameter int unsigned ADDR_W   = 16,
    parameter logic [23:0] JEDEC_ID = 24'h20BA18,
    parameter logic [7:0]  STATUS   = 8'h00
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              spi_clk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    localparam int unsigned CNT_W = 5;
    localparam int unsigned SH_W  = 24;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;
    typedef enum logic [1:0] {SRC_MEM, SRC_ID, SRC_STATUS} src_t;

    logic [2:0] clk_sync, cs_sync, mosi_sync;
    logic       rise, fall;

    state_t            state, state_n;
    src_t              src, src_n;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [SH_W-1:0]   shift_in, shift_in_n, sh_next;
    logic [7:0]        out_sh, out_sh_n;
    logic [7:0]        prefetch, prefetch_n;
    logic [1:0]        id_idx, id_idx_n;
    logic              rd_pend, rd_pend_n;
    logic              miso_n, oe_n, rd_en_n, busy_n, cmd_err_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [7:0]        id_byte;

    // Two sync flops plus an alignment stage; pulses and synced levels line up after it.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            clk_sync  <= 3'b000;
            cs_sync   <= 3'b111;
            mosi_sync <= 3'b000;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[1:0], spi_clk};
            cs_sync   <= {cs_sync[1:0], spi_cs};
            mosi_sync <= {mosi_sync[1:0], spi_mosi};
            rise      <= clk_sync[1] & ~clk_sync[2];
            fall      <= ~clk_sync[1] & clk_sync[2];
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= IDLE;
            src         <= SRC_MEM;
            bit_cnt     <= '0;
            shift_in    <= '0;
            out_sh      <= '0;
            prefetch    <= '0;
            id_idx      <= '0;
            rd_pend     <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            busy        <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            state       <= state_n;
            src         <= src_n;
            bit_cnt     <= bit_cnt_n;
            shift_in    <= shift_in_n;
            out_sh      <= out_sh_n;
            prefetch    <= prefetch_n;
            id_idx      <= id_idx_n;
            rd_pend     <= rd_pend_n;
            spi_miso    <= miso_n;
            spi_miso_oe <= oe_n;
            mem_rd_en   <= rd_en_n;
            mem_addr    <= mem_addr_n;
            busy        <= busy_n;
            cmd_err     <= cmd_err_n;
        end
    end

    always_comb begin
        case (id_idx)
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'h00;
        endcase
    end

    assign sh_next = {shift_in[SH_W-2:0], mosi_sync[2]};

    always_comb begin
        state_n    = state;
        src_n      = src;
        bit_cnt_n  = bit_cnt;
        shift_in_n = shift_in;
        out_sh_n   = out_sh;
        prefetch_n = prefetch;
        id_idx_n   = id_idx;
        rd_pend_n  = mem_rd_en;
        miso_n     = spi_miso;
        rd_en_n    = 1'b0;
        cmd_err_n  = 1'b0;
        mem_addr_n = mem_addr;

        // CS release beats any coincident clock pulse and drops in-flight reads.
        if (cs_sync[2]) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            rd_pend_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt_n  = '0;
                    shift_in_n = '0;
                    state_n    = CMD;
                end
                CMD: if (rise) begin
                    shift_in_n = sh_next;
                    bit_cnt_n  = bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(7)) begin
                        bit_cnt_n = '0;
                        case (sh_next[7:0])
                            8'h03: begin
                                state_n = ADDR;
                                src_n   = SRC_MEM;
                            end
                            8'h9F: begin
                                state_n    = DATA;
                                src_n      = SRC_ID;
                                prefetch_n = JEDEC_ID[23:16];
                                id_idx_n   = 2'd1;
                            end
                            8'h05: begin
                                state_n    = DATA;
                                src_n      = SRC_STATUS;
                                prefetch_n = STATUS;
                            end
                            default: begin
                                state_n   = IGNORE;
                                cmd_err_n = 1'b1;
                            end
                        endcase
                    end
                end
                ADDR: if (rise) begin
                    shift_in_n = sh_next;
                    bit_cnt_n  = bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(23)) begin
                        bit_cnt_n  = '0;
                        mem_addr_n = sh_next[ADDR_W-1:0];
                        rd_en_n    = 1'b1;
                        state_n    = DATA;
                    end
                end
                DATA: begin
                    // Memory data is valid the cycle after the strobe; capture it one cycle later.
                    if (rd_pend) prefetch_n = mem_rdata;
                    if (fall) begin
                        if (bit_cnt[2:0] == 3'd0) begin
                            miso_n   = prefetch[7];
                            out_sh_n = {prefetch[6:0], 1'b0};
                            case (src)
                                SRC_MEM: begin
                                    rd_en_n    = 1'b1;
                                    mem_addr_n = mem_addr + ADDR_W'(1);
                                end
                                SRC_ID: begin
                                    prefetch_n = id_byte;
                                    id_idx_n   = (id_idx == 2'd3) ? 2'd3 : id_idx + 2'd1;
                                end
                                default: ;
                            endcase
                        end else begin
                            miso_n   = out_sh[7];
                            out_sh_n = {out_sh[6:0], 1'b0};
                        end
                        bit_cnt_n = {2'b00, bit_cnt[2:0] + 3'd1};
                    end
                end
                IGNORE: ;
                default: state_n = IDLE;
            endcase
        end

        oe_n   = (state_n == DATA);
        busy_n = (state_n != IDLE);
        if (state_n != DATA) miso_n = 1'b0;
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: bit-banged SPI master plus a simple byte memory.
module tb_spi_flash_responder;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned H      = 8;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic              spi_clk = 1'b0;
    logic              spi_cs  = 1'b1;
    logic              spi_mosi = 1'b0;
    logic              spi_miso, spi_miso_oe, mem_rd_en, busy, cmd_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata = 8'h00;

    logic [7:0]  tx_buf [0:7];
    logic [7:0]  rx_buf [0:7];
    logic [15:0] rd_log [0:63];
    int          rd_cnt = 0, err_cnt = 0, oe_cnt = 0;
    logic        rd_prev = 1'b0, consec = 1'b0;
    int          tests = 0, fails = 0;
    int          rd0, err0, oe0;

    spi_flash_responder #(
        .ADDR_W  (ADDR_W),
        .JEDEC_ID(24'h20BA18),
        .STATUS  (8'h5A)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .spi_clk    (spi_clk),
        .spi_cs     (spi_cs),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .cmd_err    (cmd_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Memory contents: mem[a] = a[7:0] ^ 0xA5, one-cycle read latency.
    always @(posedge sys_clk) if (mem_rd_en) mem_rdata <= mem_addr[7:0] ^ 8'hA5;

    always @(negedge sys_clk) begin
        if (mem_rd_en) begin
            if (rd_prev) consec = 1'b1;
            if (rd_cnt < 64) rd_log[rd_cnt] = mem_addr;
            rd_cnt++;
        end
        rd_prev = mem_rd_en;
        if (cmd_err) err_cnt++;
        if (spi_miso_oe) oe_cnt++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
        for (int i = 0; i < 8; i++) begin
            tx_buf[i] = 8'h00;
            rx_buf[i] = 8'h00;
        end
        tx_buf[0] = b0; tx_buf[1] = b1; tx_buf[2] = b2; tx_buf[3] = b3;
    endtask

    // Mode-0 master; with close=1 the last clock fall and CS release happen together.
    task automatic spi_run(input int nbits, input bit close);
        @(negedge sys_clk);
        spi_cs = 1'b0;
        repeat (H) @(negedge sys_clk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx_buf[i >> 3][3'(7 - (i % 8))];
            repeat (H) @(negedge sys_clk);
            spi_clk = 1'b1;
            rx_buf[i >> 3][3'(7 - (i % 8))] = spi_miso;
            repeat (H) @(negedge sys_clk);
            spi_clk = 1'b0;
            if (close && i == nbits - 1) spi_cs = 1'b1;
        end
        if (close) repeat (12) @(negedge sys_clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_miso"}, 32'(spi_miso), 32'h0);
        check({tag, "_oe"}, 32'(spi_miso_oe), 32'h0);
        check({tag, "_rd_en"}, 32'(mem_rd_en), 32'h0);
        check({tag, "_addr"}, 32'(mem_addr), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_cmd_err"}, 32'(cmd_err), 32'h0);
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        check_outputs_zero("reset");
        sys_rst = 1'b0;
        repeat (5) @(negedge sys_clk);
        check("idle_busy", 32'(busy), 32'h0);

        // READ at 0x000010, 4 bytes
        load(8'h03, 8'h00, 8'h00, 8'h10);
        rd0 = rd_cnt;
        spi_run(64, 1'b1);
        check("read_b0", 32'(rx_buf[4]), 32'hB5);
        check("read_b1", 32'(rx_buf[5]), 32'hB4);
        check("read_b2", 32'(rx_buf[6]), 32'hB7);
        check("read_b3", 32'(rx_buf[7]), 32'hB6);
        check("read_rd_count", 32'(rd_cnt - rd0), 32'd5);
        for (int k = 0; k < 5; k++)
            check("read_addr", 32'(rd_log[rd0 + k]), 32'h10 + 32'(k));
        check("read_busy_after", 32'(busy), 32'h0);
        check("read_oe_after", 32'(spi_miso_oe), 32'h0);

        // READ wrapping through 0xFFFF
        load(8'h03, 8'h00, 8'hFF, 8'hFE);
        rd0 = rd_cnt;
        spi_run(64, 1'b1);
        check("wrap_b0", 32'(rx_buf[4]), 32'h5B);
        check("wrap_b1", 32'(rx_buf[5]), 32'h5A);
        check("wrap_b2", 32'(rx_buf[6]), 32'hA5);
        check("wrap_b3", 32'(rx_buf[7]), 32'hA4);
        check("wrap_addr0", 32'(rd_log[rd0]), 32'hFFFE);
        check("wrap_addr1", 32'(rd_log[rd0 + 1]), 32'hFFFF);
        check("wrap_addr2", 32'(rd_log[rd0 + 2]), 32'h0000);
        check("wrap_addr3", 32'(rd_log[rd0 + 3]), 32'h0001);

        // READ ID, 5 bytes
        load(8'h9F, 8'h00, 8'h00, 8'h00);
        rd0 = rd_cnt;
        spi_run(48, 1'b1);
        check("id_b0", 32'(rx_buf[1]), 32'h20);
        check("id_b1", 32'(rx_buf[2]), 32'hBA);
        check("id_b2", 32'(rx_buf[3]), 32'h18);
        check("id_b3", 32'(rx_buf[4]), 32'h00);
        check("id_b4", 32'(rx_buf[5]), 32'h00);
        check("id_no_rd", 32'(rd_cnt - rd0), 32'd0);

        // READ STATUS, 3 bytes
        load(8'h05, 8'h00, 8'h00, 8'h00);
        rd0 = rd_cnt;
        spi_run(32, 1'b1);
        check("status_b0", 32'(rx_buf[1]), 32'h5A);
        check("status_b1", 32'(rx_buf[2]), 32'h5A);
        check("status_b2", 32'(rx_buf[3]), 32'h5A);
        check("status_no_rd", 32'(rd_cnt - rd0), 32'd0);

        // Unsupported opcode, then a normal READ ID
        load(8'hAB, 8'hFF, 8'hFF, 8'h00);
        err0 = err_cnt;
        oe0  = oe_cnt;
        spi_run(24, 1'b1);
        check("bad_cmd_err", 32'(err_cnt - err0), 32'd1);
        check("bad_cmd_oe", 32'(oe_cnt - oe0), 32'd0);
        check("bad_cmd_miso", 32'({rx_buf[1], rx_buf[2]}), 32'h0);
        load(8'h9F, 8'h00, 8'h00, 8'h00);
        spi_run(32, 1'b1);
        check("post_bad_id0", 32'(rx_buf[1]), 32'h20);
        check("post_bad_id1", 32'(rx_buf[2]), 32'hBA);
        check("post_bad_id2", 32'(rx_buf[3]), 32'h18);

        // CS released after 13 address bits
        load(8'h03, 8'h12, 8'h34, 8'h56);
        rd0 = rd_cnt;
        spi_run(21, 1'b1);
        check("abort_no_rd", 32'(rd_cnt - rd0), 32'd0);
        check("abort_busy", 32'(busy), 32'h0);

        // Reset pulse in the middle of DATA
        load(8'h03, 8'h00, 8'h00, 8'h40);
        spi_run(44, 1'b0);
        check("mid_data_oe", 32'(spi_miso_oe), 32'h1);
        check("mid_data_busy", 32'(busy), 32'h1);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        check_outputs_zero("mid_rst");
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        spi_cs  = 1'b1;
        repeat (10) @(negedge sys_clk);
        load(8'h03, 8'h00, 8'h00, 8'h20);
        spi_run(48, 1'b1);
        check("post_rst_b0", 32'(rx_buf[4]), 32'h85);
        check("post_rst_b1", 32'(rx_buf[5]), 32'h84);

        check("rd_en_never_back_to_back", 32'(consec), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
